axi4_wr_burst_req_split: RTL and testbench
==========================================

Name: axi4_wr_burst_req_split

Overview:
- Upstream command stage for the AXI4 write auxiliary generator.
- Accepts one large write request (id, start address, total beat count).
- Splits it into AXI4-legal bursts: no burst longer than MAX_BURST, none crossing a 4 KB boundary.
- Emits each burst as a {id, addr, len} stream word, in the exact packing the aux generator consumes on its id/addr/len slave stream.

Parameters:
- ASIZE, 32, address width in bits
- IDSIZE, 4, AXI ID width
- LSIZE, 8, AXI len width; MAX_BURST must be <= 2**LSIZE
- DSIZE, 64, write data width in bits; BYTES = DSIZE/8 (power of 2, 8..128)
- CSIZE, 32, width of the total-beat-count field
- MAX_BURST, 256, maximum beats per emitted burst

Ports:
- clock  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_id  in  IDSIZE  AXI ID applied to every sub-burst
- req_addr  in  ASIZE  start byte address; low log2(BYTES) bits ignored (forced 0)
- req_beats  in  CSIZE  total beats; 0 is legal (see Behaviour)
- out_tvalid  out  1  burst descriptor valid
- out_tready  in  1  downstream ready
- out_tdata  out  IDSIZE+ASIZE+LSIZE  {id, addr, len} MSB->LSB; len = beats-1
- out_tlast  out  1  high on the final sub-burst of a request
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; req_ready=0 while rst asserted, 1 from the first clock after release.
  - out_tvalid=0, out_tdata=0, out_tlast=0, busy=0.
  - All internal registers cleared.
- Reset mid-operation abandons the request at once. No further descriptors are emitted and no partial output is held.
- States: IDLE, CALC, SEND.
- IDLE:
  - req_ready=1 (decoded from the state register).
  - On accept, latch id, addr (low bits zeroed) and rem=req_beats.
  - Go to CALC if req_beats!=0. If req_beats==0, discard the request and stay IDLE; no output.
- CALC (1 cycle):
  - to4k = (4096 - addr[11:0]) / BYTES, 13-bit unsigned.
  - burst = min(rem, MAX_BURST, to4k).
  - Register len=burst-1 (LSIZE bits) and last=(rem==burst).
  - Go to SEND.
- SEND:
  - out_tvalid=1; out_tdata and out_tlast are registered and held stable until the handshake.
  - On out_tvalid && out_tready:
    - addr += burst*BYTES, ASIZE bits, wraps modulo 2**ASIZE;
    - rem -= burst;
    - go to IDLE if last, else CALC.
- Latency: accept at cycle N -> first out_tvalid at N+2.
  - Each subsequent descriptor appears 2 cycles after the previous handshake.
  - Next req_ready=1 comes 1 cycle after the final handshake.
- req_ready=0 in CALC and SEND. A new request is never accepted while a split is in progress.
- out_tvalid never deasserts without a handshake.
- to4k is never 0, because addr is beat-aligned, so burst >= 1 always.
- A request ending exactly on a 4 KB boundary emits no empty trailing burst.
- Simultaneous rst and handshake: rst wins.

Test Plan:
- addr=0x0, beats=600, out_tready=1 -> exactly 3 descriptors:
  - len=255 @0x000;
  - len=255 @0x800;
  - len=87 @0x1000, with tlast only on the third.
- addr=0xFF0, beats=10 -> len=1 @0xFF0 (to4k=2 beats), then len=7 @0x1000 with tlast=1.
- addr=0x1004 (unaligned), beats=1 -> single len=0 @0x1000, tlast=1; busy drops on the cycle after the handshake.
- beats=0 -> request accepted and discarded; req_ready is 1 again the next cycle; no out_tvalid ever.
- Backpressure, addr=0x0, beats=600, out_tready held 0 for 5 cycles at each descriptor -> tvalid stays 1 and tdata/tlast stay constant; descriptor sequence identical to the first scenario.
- Assert rst during the second SEND of the 600-beat request -> out_tvalid=0 and busy=0 asynchronously; after release the first descriptor of a new request starts at its own address.

Source files
------------

// File: rtl/axi4_wr_burst_req_split.sv
// Splits one large AXI4 write request into bursts that never exceed MAX_BURST
// beats or cross a 4 KB page, emitted as {id, addr, len} stream words.
module axi4_wr_burst_req_split #(
    parameter int ASIZE     = 32,
    parameter int IDSIZE    = 4,
    parameter int LSIZE     = 8,
    parameter int DSIZE     = 64,
    parameter int CSIZE     = 32,
    parameter int MAX_BURST = 256
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [IDSIZE-1:0]             req_id,
    input  logic [ASIZE-1:0]              req_addr,
    input  logic [CSIZE-1:0]              req_beats,
    output logic                          out_tvalid,
    input  logic                          out_tready,
    output logic [IDSIZE+ASIZE+LSIZE-1:0] out_tdata,
    output logic                          out_tlast,
    output logic                          busy
);

    // state | meaning
    // IDLE  | waiting for a request; req_ready high
    // CALC  | sizing the next burst from remaining beats and 4 KB headroom
    // SEND  | descriptor presented downstream until accepted

    localparam int BYTES = DSIZE / 8;
    localparam int BSH   = $clog2(BYTES);
    localparam logic [ASIZE-1:0] ALIGN_MASK = ~ASIZE'(BYTES - 1);
    localparam logic [CSIZE-1:0] MAX_C      = CSIZE'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [IDSIZE-1:0] id_q;
    logic [ASIZE-1:0]  addr_q;
    logic [CSIZE-1:0]  rem_q;
    logic [LSIZE-1:0]  len_q;
    logic [LSIZE:0]    burst_q;
    logic              last_q;
    logic              rdy_en_q;

    logic              req_fire;
    logic              out_fire;
    logic [12:0]       to4k;
    logic [CSIZE-1:0]  cap;
    logic [CSIZE-1:0]  burst_c;

    assign req_fire = req_valid && req_ready;
    assign out_fire = out_tvalid && out_tready;

    // addr_q is beat-aligned, so to4k is always at least one beat
    assign to4k = (13'h1000 - {1'b0, addr_q[11:0]}) >> BSH;

    always_comb begin
        cap     = (MAX_C < CSIZE'(to4k)) ? MAX_C : CSIZE'(to4k);
        burst_c = (rem_q < cap) ? rem_q : cap;
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_fire && (req_beats != '0)) state_nxt = CALC;
            CALC: state_nxt = SEND;
            SEND: if (out_fire) state_nxt = last_q ? IDLE : CALC;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = rdy_en_q && (state == IDLE);
        out_tvalid = (state == SEND);
        busy       = (state != IDLE);
        out_tdata  = {id_q, addr_q, len_q};
        out_tlast  = last_q && (state == SEND);
    end

    // rdy_en_q keeps req_ready low until the first clock after reset release
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            rdy_en_q <= 1'b0;
            id_q     <= '0;
            addr_q   <= '0;
            rem_q    <= '0;
            len_q    <= '0;
            burst_q  <= '0;
            last_q   <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        id_q   <= req_id;
                        addr_q <= req_addr & ALIGN_MASK;
                        rem_q  <= req_beats;
                    end
                end
                CALC: begin
                    len_q   <= LSIZE'(burst_c - CSIZE'(1));
                    burst_q <= burst_c[LSIZE:0];
                    last_q  <= (rem_q == burst_c);
                end
                SEND: begin
                    if (out_fire) begin
                        addr_q <= addr_q + (ASIZE'(burst_q) << BSH);
                        rem_q  <= rem_q - CSIZE'(burst_q);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_wr_burst_req_split.sv
// Directed bench for axi4_wr_burst_req_split: hand-computed descriptor
// sequences, backpressure, zero-beat requests and mid-split reset.
module tb_axi4_wr_burst_req_split;

    localparam int TW = 4 + 32 + 8;

    logic          clock;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_id;
    logic [31:0]   req_addr;
    logic [31:0]   req_beats;
    logic          out_tvalid;
    logic          out_tready;
    logic [TW-1:0] out_tdata;
    logic          out_tlast;
    logic          busy;

    int n_vec = 0;
    int n_err = 0;

    axi4_wr_burst_req_split #(
        .ASIZE(32), .IDSIZE(4), .LSIZE(8), .DSIZE(64), .CSIZE(32), .MAX_BURST(256)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_id    (req_id),
        .req_addr  (req_addr),
        .req_beats (req_beats),
        .out_tvalid(out_tvalid),
        .out_tready(out_tready),
        .out_tdata (out_tdata),
        .out_tlast (out_tlast),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one request at a negedge; returns at the negedge after acceptance
    task automatic send_req(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] beats);
        req_id    = id;
        req_addr  = addr;
        req_beats = beats;
        req_valid = 1'b1;
        chk("req_ready_before_accept", 64'(req_ready), 64'd1);
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
    endtask

    // Waits for one descriptor, optionally stalls it 5 cycles, checks and accepts it
    task automatic get_desc(input string tag, input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic last, input bit stall);
        int cnt;
        logic [TW-1:0] exp_data;
        exp_data = {id, addr, len};
        cnt = 0;
        while (!out_tvalid && cnt < 40) begin
            @(negedge clock);
            cnt++;
        end
        chk({tag, "_wait"}, 64'(cnt), 64'd1);
        if (!out_tvalid) return;
        chk({tag, "_tdata"}, 64'(out_tdata), 64'(exp_data));
        chk({tag, "_tlast"}, 64'(out_tlast), 64'(last));
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        if (stall) begin
            out_tready = 1'b0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clock);
                chk({tag, "_stall_tvalid"}, 64'(out_tvalid), 64'd1);
                chk({tag, "_stall_tdata"}, 64'(out_tdata), 64'(exp_data));
                chk({tag, "_stall_tlast"}, 64'(out_tlast), 64'(last));
            end
            out_tready = 1'b1;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_idle_tvalid"}, 64'(out_tvalid), 64'd0);
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
        chk({tag, "_idle_req_ready"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_id     = '0;
        req_addr   = '0;
        req_beats  = '0;
        out_tready = 1'b1;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_tvalid", 64'(out_tvalid), 64'd0);
        chk("rst_tdata", 64'(out_tdata), 64'd0);
        chk("rst_tlast", 64'(out_tlast), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(negedge clock);
        @(negedge clock);
        rst = 1'b0;
        #1 chk("rel_req_ready_low", 64'(req_ready), 64'd0);
        @(negedge clock);
        chk("rel_req_ready_high", 64'(req_ready), 64'd1);

        // 600 beats from 0x0: 256 + 256 + 88
        send_req(4'h3, 32'h0, 32'd600);
        chk("s1_calc_tvalid", 64'(out_tvalid), 64'd0);
        chk("s1_calc_busy", 64'(busy), 64'd1);
        get_desc("s1_d0", 4'h3, 32'h0000, 8'd255, 1'b0, 1'b0);
        get_desc("s1_d1", 4'h3, 32'h0800, 8'd255, 1'b0, 1'b0);
        get_desc("s1_d2", 4'h3, 32'h1000, 8'd87, 1'b1, 1'b0);
        check_idle("s1");

        // 4 KB crossing: 2 beats then 8
        send_req(4'h5, 32'h0FF0, 32'd10);
        get_desc("s2_d0", 4'h5, 32'h0FF0, 8'd1, 1'b0, 1'b0);
        get_desc("s2_d1", 4'h5, 32'h1000, 8'd7, 1'b1, 1'b0);
        check_idle("s2");

        // Unaligned single beat
        send_req(4'h9, 32'h1004, 32'd1);
        get_desc("s3_d0", 4'h9, 32'h1000, 8'd0, 1'b1, 1'b0);
        check_idle("s3");

        // Zero beats: discarded
        send_req(4'h1, 32'h2000, 32'd0);
        check_idle("s4");
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("s4_no_tvalid", 64'(out_tvalid), 64'd0);
        end

        // Backpressure on every descriptor
        send_req(4'h6, 32'h0, 32'd600);
        get_desc("s5_d0", 4'h6, 32'h0000, 8'd255, 1'b0, 1'b1);
        get_desc("s5_d1", 4'h6, 32'h0800, 8'd255, 1'b0, 1'b1);
        get_desc("s5_d2", 4'h6, 32'h1000, 8'd87, 1'b1, 1'b1);
        check_idle("s5");

        // Reset during the second SEND
        send_req(4'h7, 32'h0, 32'd600);
        get_desc("s6_d0", 4'h7, 32'h0000, 8'd255, 1'b0, 1'b0);
        @(negedge clock);
        chk("s6_second_tvalid", 64'(out_tvalid), 64'd1);
        rst = 1'b1;
        #1;
        chk("s6_rst_tvalid", 64'(out_tvalid), 64'd0);
        chk("s6_rst_busy", 64'(busy), 64'd0);
        chk("s6_rst_tdata", 64'(out_tdata), 64'd0);
        chk("s6_rst_req_ready", 64'(req_ready), 64'd0);
        @(negedge clock);
        rst = 1'b0;
        #1 chk("s6_rel_req_ready_low", 64'(req_ready), 64'd0);
        @(negedge clock);
        chk("s6_rel_tvalid", 64'(out_tvalid), 64'd0);
        send_req(4'hA, 32'h2340, 32'd5);
        get_desc("s6_new", 4'hA, 32'h2340, 8'd4, 1'b1, 1'b0);
        check_idle("s6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
